mips_bus_arbiter: RTL and testbench
===================================

# mips_bus_arbiter

Parametrised Avalon-MM bus master that lets several requesters inside the CPU share the single external memory bus: fetch, data load/store and future prefetch or debug ports. Each channel issues one transaction through a valid/accept handshake. The block arbitrates in fixed-priority or round-robin mode, drives the Avalon `read`/`write`/`byteenable` signals, holds them through `waitrequest`, and returns read data on a per-channel response strobe. An optional watchdog flags bus transfers that never complete.

## Interface
Parameters:
- `N_CHANNELS`, 2: number of requester channels (1..8); channel 0 is highest priority in fixed mode.
- `ROUND_ROBIN`, 1: 1 = rotating priority; 0 = fixed priority, lowest index wins.
- `WAIT_TIMEOUT`, 0: maximum consecutive `waitrequest` cycles in BUS before abort; 0 disables the watchdog.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low (0 = reset).
- `req_valid`  in  N_CHANNELS  channel n has a pending request.
- `req_write`  in  N_CHANNELS  1 = write, 0 = read.
- `req_address`  in  N_CHANNELS×32  byte address (packed array).
- `req_writedata`  in  N_CHANNELS×32  write data.
- `req_byteenable`  in  N_CHANNELS×4  lane enables.
- `req_accept`  out  N_CHANNELS  one-cycle pulse: channel's transfer completed on the bus.
- `resp_valid`  out  N_CHANNELS  one-cycle pulse: `resp_readdata` is valid for that channel (reads only).
- `resp_readdata`  out  32  registered read data; shared by all channels.
- `busy`  out  1  FSM not in IDLE.
- `bus_error`  out  1  sticky; set on watchdog abort; cleared only by reset.
- `address`, `write`, `read`, `writedata`, `byteenable`  out  Avalon master outputs, 32/1/1/32/4.
- `waitrequest`  in  1 and `readdata`  in  32: Avalon inputs.

## Operation
- Requester rules:
  - Holds `req_valid` and all request fields stable from assertion until its `req_accept` pulse.
  - May not drop a request early.
  - May re-assert `req_valid` in the cycle after `req_accept`.
- States are IDLE, BUS, RESP.
- IDLE:
  - If any `req_valid` is set, pick a winner g.
  - Latch g's `req_write`, `req_address`, `req_writedata` and `req_byteenable` into internal registers.
  - Move to BUS.
  - With no requests, stay in IDLE.
- BUS:
  - Drive `address`/`writedata`/`byteenable` from the latched registers, with `read = ~wr` and `write = wr`.
  - On `waitrequest = 0`:
    - Pulse `req_accept[g]`.
    - For a read, capture `readdata` into `resp_readdata` and go to RESP.
    - For a write, go to IDLE.
- RESP: pulse `resp_valid[g]` for one cycle, then go to IDLE.
- Arbitration:
  - Round-robin: search starts at `last_grant + 1` modulo `N_CHANNELS` and wraps; `last_grant` updates to g on every grant.
  - Fixed priority: lowest set index wins; `last_grant` is unused.
- Watchdog (`WAIT_TIMEOUT` > 0):
  - Counter clears on BUS entry and increments each BUS cycle with `waitrequest = 1`.
  - When the count reaches `WAIT_TIMEOUT`:
    - Deassert `read`/`write` and set `bus_error`.
    - Pulse `req_accept[g]`; for a read, also pulse `resp_valid[g]` with `resp_readdata` = 32'hDEAD_BEEF.
    - Return to IDLE.
- At most one bit of `req_accept` and at most one bit of `resp_valid` is high in any cycle.

## Timing
- Reset values, applied immediately and asynchronously:
  - State IDLE.
  - All outputs 0, including `bus_error`.
  - `last_grant` = N_CHANNELS−1, so channel 0 wins the first round-robin grant.
  - Watchdog counter 0.
- Reset in mid-transfer: the transaction is dropped, with no `req_accept` and no `resp_valid`. Requesters must re-issue.
- Latency with `waitrequest` low:
  - Write: request in cycle 0, bus strobe in cycle 1, `req_accept` in cycle 1; minimum 2 cycles per write.
  - Read: as for a write, plus `resp_valid` in cycle 2; minimum 3 cycles per read.
- Each stall cycle (`waitrequest` high) adds exactly one cycle. Bus outputs stay constant throughout BUS.
- `read` and `write` are never both high. Both are low in IDLE and RESP.
- A new request arriving in the same cycle as another channel's `req_accept` is considered in the next IDLE cycle. No grant is made in BUS or RESP.
- With `N_CHANNELS = 1`, the round-robin and fixed-priority modes behave identically.

## Structure
- Package `mips_bus_pkg`:
  - `bus_state_t` enum (IDLE, BUS, RESP).
  - Localparam `BUS_ERR_DATA` = 32'hDEAD_BEEF.
  - Lane-width constants.
- Sub-module `bus_rr_arbiter`:
  - Combinational.
  - Inputs: `req` vector, `last_grant`, mode.
  - Outputs: one-hot `grant` and binary `grant_idx`.
- The top-level module holds the FSM, latched request registers, watchdog counter and response register.

## Test plan
- Single read, ch0, address 0x1000, `waitrequest` low, `readdata` 0x12345678 → `read` high in cycle 1, `req_accept[0]` in cycle 1, `resp_valid[0]` with 0x12345678 in cycle 2.
- Write with three stall cycles, ch1, 0x2004, data 0xCAFEF00D, `byteenable` 4'b0011 → bus outputs held constant for 4 cycles, `req_accept[1]` on the 4th BUS cycle, no `resp_valid`.
- Round-robin, both channels continuously valid → grants alternate 0, 1, 0, 1. Fixed priority under the same stimulus → ch0 is granted every time and ch1 starves.
- `WAIT_TIMEOUT` = 5, `waitrequest` stuck high on a read → abort after 5 stall cycles, `bus_error` = 1 and stays 1, `resp_readdata` = 0xDEADBEEF.
- `reset` driven to 0 in mid-BUS → `read`/`write`/`busy` go to 0 immediately. After release, ch0 wins first, and no stale `req_accept` or `resp_valid` appears.

Source files
------------

// File: rtl/mips_bus_arbiter_pkg.sv
// Shared types and constants for the external memory bus arbiter.
package mips_bus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } bus_state_t;

  localparam logic [31:0] BUS_ERR_DATA = 32'hDEAD_BEEF;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int BE_W   = DATA_W / 8;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mips_bus_arbiter_if.sv
// Requester channels plus Avalon-MM master signals of the external bus.
interface mips_bus_arbiter_if #(
  parameter int N_CHANNELS = 2
);
  import mips_bus_pkg::*;

  logic [N_CHANNELS-1:0]             req_valid;
  logic [N_CHANNELS-1:0]             req_write;
  logic [N_CHANNELS-1:0][ADDR_W-1:0] req_address;
  logic [N_CHANNELS-1:0][DATA_W-1:0] req_writedata;
  logic [N_CHANNELS-1:0][BE_W-1:0]   req_byteenable;
  logic [N_CHANNELS-1:0]             req_accept;
  logic [N_CHANNELS-1:0]             resp_valid;
  logic [DATA_W-1:0]                 resp_readdata;

  logic [ADDR_W-1:0] address;
  logic              write;
  logic              read;
  logic [DATA_W-1:0] writedata;
  logic [BE_W-1:0]   byteenable;
  logic              waitrequest;
  logic [DATA_W-1:0] readdata;

  modport master (
    input  req_valid, req_write, req_address, req_writedata, req_byteenable,
    input  waitrequest, readdata,
    output req_accept, resp_valid, resp_readdata,
    output address, write, read, writedata, byteenable
  );

  modport slave (
    output req_valid, req_write, req_address, req_writedata, req_byteenable,
    output waitrequest, readdata,
    input  req_accept, resp_valid, resp_readdata,
    input  address, write, read, writedata, byteenable
  );

endinterface

// File: rtl/mips_bus_arbiter_rr_arbiter.sv
// Combinational channel picker: rotating search from last_grant+1, or lowest index first.
module bus_rr_arbiter #(
  parameter int N     = 2,
  parameter int IDX_W = 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] last_grant,
  input  logic             round_robin,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx
);

  always_comb begin
    int   start;
    int   idx;
    logic found;
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    start     = round_robin ? ((int'(last_grant) + 1) % N) : 0;
    for (int k = 0; k < N; k++) begin
      idx = (start + k) % N;
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/mips_bus_arbiter.sv
// Avalon-MM bus master shared by the CPU's requester channels, with optional
// waitrequest watchdog.
module mips_bus_arbiter
  import mips_bus_pkg::*;
#(
  parameter int N_CHANNELS   = 2,
  parameter int ROUND_ROBIN  = 1,
  parameter int WAIT_TIMEOUT = 0
) (
  input  logic               clk,
  input  logic               reset,
  mips_bus_arbiter_if.master bus,
  output logic               busy,
  output logic               bus_error
);

  // state | meaning
  // IDLE  | no transfer; pick a winner when any req_valid is set
  // BUS   | Avalon strobe driven from latched request until waitrequest drops
  // RESP  | one-cycle resp_valid pulse for a completed read
  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_BUS  = BUS;
  localparam logic [1:0] ST_RESP = RESP;

  localparam int IDX_W = idx_width(N_CHANNELS);
  localparam bit WD_EN = (WAIT_TIMEOUT > 0);
  localparam int CNT_W = WD_EN ? $clog2(WAIT_TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] TO_VAL  = CNT_W'(WD_EN ? WAIT_TIMEOUT : 0);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(WD_EN ? WAIT_TIMEOUT - 1 : 0);

  logic [1:0]        state;
  logic [IDX_W-1:0]  g_q;
  logic [IDX_W-1:0]  last_grant;
  logic              wr_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [BE_W-1:0]   be_q;
  logic [CNT_W-1:0]  wd_cnt;
  logic [DATA_W-1:0] resp_q;

  logic [N_CHANNELS-1:0] grant;
  logic [IDX_W-1:0]      grant_idx;
  logic                  sel_write;
  logic [ADDR_W-1:0]     sel_address;
  logic [DATA_W-1:0]     sel_writedata;
  logic [BE_W-1:0]       sel_be;
  logic                  in_bus;
  logic                  timeout;
  logic                  stall_to;
  logic                  done;

  bus_rr_arbiter #(
    .N     (N_CHANNELS),
    .IDX_W (IDX_W)
  ) u_arb (
    .req         (bus.req_valid),
    .last_grant  (last_grant),
    .round_robin (ROUND_ROBIN != 0),
    .grant       (grant),
    .grant_idx   (grant_idx)
  );

  always_comb begin
    sel_write     = 1'b0;
    sel_address   = '0;
    sel_writedata = '0;
    sel_be        = '0;
    for (int n = 0; n < N_CHANNELS; n++) begin
      if (grant[n]) begin
        sel_write     = bus.req_write[n];
        sel_address   = bus.req_address[n];
        sel_writedata = bus.req_writedata[n];
        sel_be        = bus.req_byteenable[n];
      end
    end
  end

  // timeout is the abort cycle; stall_to is the stall that makes the count reach the limit
  assign in_bus   = (state == ST_BUS);
  assign timeout  = WD_EN && in_bus && (wd_cnt == TO_VAL);
  assign stall_to = WD_EN && in_bus && bus.waitrequest && !timeout && (wd_cnt == TO_LAST);
  assign done     = in_bus && (!bus.waitrequest || timeout);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      g_q        <= '0;
      last_grant <= IDX_W'(N_CHANNELS - 1);
      wr_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      be_q       <= '0;
      wd_cnt     <= '0;
      resp_q     <= '0;
      bus_error  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (|bus.req_valid) begin
            g_q     <= grant_idx;
            wr_q    <= sel_write;
            addr_q  <= sel_address;
            wdata_q <= sel_writedata;
            be_q    <= sel_be;
            wd_cnt  <= '0;
            if (ROUND_ROBIN != 0) last_grant <= grant_idx;
            state   <= ST_BUS;
          end
        end
        ST_BUS: begin
          if (done) begin
            if (timeout) begin
              state <= ST_IDLE;
            end else if (!wr_q) begin
              resp_q <= bus.readdata;
              state  <= ST_RESP;
            end else begin
              state <= ST_IDLE;
            end
          end else if (WD_EN) begin
            wd_cnt <= wd_cnt + 1'b1;
          end
          // preload the error word so the abort cycle returns it from the register
          if (stall_to) begin
            bus_error <= 1'b1;
            if (!wr_q) resp_q <= BUS_ERR_DATA;
          end
        end
        ST_RESP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    bus.req_accept = '0;
    bus.resp_valid = '0;
    for (int n = 0; n < N_CHANNELS; n++) begin
      if (g_q == IDX_W'(n)) begin
        bus.req_accept[n] = done;
        bus.resp_valid[n] = (state == ST_RESP) || (timeout && !wr_q);
      end
    end
  end

  assign bus.resp_readdata = resp_q;
  assign bus.address       = addr_q;
  assign bus.writedata     = wdata_q;
  assign bus.byteenable    = be_q;
  assign bus.read          = in_bus && !wr_q && !timeout;
  assign bus.write         = in_bus && wr_q && !timeout;
  assign busy              = (state != ST_IDLE);

endmodule

// File: tb/tb_mips_bus_arbiter.sv
// Directed bench: round-robin instance with watchdog plus a fixed-priority instance.
module tb_mips_bus_arbiter;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mips_bus_arbiter_if #(.N_CHANNELS(2)) ia ();
  mips_bus_arbiter_if #(.N_CHANNELS(2)) ib ();

  logic busy_a, err_a, busy_b, err_b;

  mips_bus_arbiter #(.N_CHANNELS(2), .ROUND_ROBIN(1), .WAIT_TIMEOUT(5)) dut_rr (
    .clk       (clk),
    .reset     (reset),
    .bus       (ia.master),
    .busy      (busy_a),
    .bus_error (err_a)
  );

  mips_bus_arbiter #(.N_CHANNELS(2), .ROUND_ROBIN(0), .WAIT_TIMEOUT(0)) dut_fp (
    .clk       (clk),
    .reset     (reset),
    .bus       (ib.master),
    .busy      (busy_b),
    .bus_error (err_b)
  );

  int passed = 0;
  int total  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  logic [1:0] exp_rr [8];
  logic [1:0] exp_fp [8];

  initial begin
    exp_rr = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00};
    exp_fp = '{2'b01, 2'b00, 2'b01, 2'b00, 2'b01, 2'b00, 2'b01, 2'b00};

    reset = 1'b0;
    ia.req_valid = '0; ia.req_write = '0; ia.req_address = '0;
    ia.req_writedata = '0; ia.req_byteenable = '0;
    ia.waitrequest = 1'b0; ia.readdata = '0;
    ib.req_valid = '0; ib.req_write = '0; ib.req_address = '0;
    ib.req_writedata = '0; ib.req_byteenable = '0;
    ib.waitrequest = 1'b0; ib.readdata = '0;

    // reset values
    step(); step();
    chk("rst_busy", busy_a, 0);
    chk("rst_err", err_a, 0);
    chk("rst_read", ia.read, 0);
    chk("rst_write", ia.write, 0);
    chk("rst_accept", ia.req_accept, 0);
    chk("rst_resp", ia.resp_valid, 0);
    chk("rst_rdata", ia.resp_readdata, 0);
    chk("rst_addr", ia.address, 0);
    chk("rst_busy_fp", busy_b, 0);
    reset = 1'b1;

    // single read ch0
    step();
    ia.req_valid = 2'b01; ia.req_write = 2'b00;
    ia.req_address[0] = 32'h0000_1000; ia.req_byteenable[0] = 4'hF;
    ia.waitrequest = 1'b0; ia.readdata = 32'h1234_5678;
    #1;
    chk("rd_c0_read", ia.read, 0);
    chk("rd_c0_busy", busy_a, 0);
    step();
    chk("rd_c1_read", ia.read, 1);
    chk("rd_c1_write", ia.write, 0);
    chk("rd_c1_addr", ia.address, 32'h0000_1000);
    chk("rd_c1_be", ia.byteenable, 32'hF);
    chk("rd_c1_accept", ia.req_accept, 32'h1);
    chk("rd_c1_resp", ia.resp_valid, 0);
    ia.req_valid = 2'b00;
    step();
    chk("rd_c2_resp", ia.resp_valid, 32'h1);
    chk("rd_c2_rdata", ia.resp_readdata, 32'h1234_5678);
    chk("rd_c2_read", ia.read, 0);
    chk("rd_c2_accept", ia.req_accept, 0);
    step();
    chk("rd_c3_busy", busy_a, 0);
    chk("rd_c3_resp", ia.resp_valid, 0);

    // write ch1 with three stall cycles
    ia.req_valid = 2'b10; ia.req_write = 2'b10;
    ia.req_address[1] = 32'h0000_2004; ia.req_writedata[1] = 32'hCAFE_F00D;
    ia.req_byteenable[1] = 4'b0011; ia.waitrequest = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      if (i == 3) begin
        ia.waitrequest = 1'b0;
        #1;
      end
      chk("wr_write", ia.write, 1);
      chk("wr_read", ia.read, 0);
      chk("wr_addr", ia.address, 32'h0000_2004);
      chk("wr_wdata", ia.writedata, 32'hCAFE_F00D);
      chk("wr_be", ia.byteenable, 32'h3);
      chk("wr_accept", ia.req_accept, (i == 3) ? 32'h2 : 32'h0);
      chk("wr_resp", ia.resp_valid, 0);
    end
    ia.req_valid = 2'b00;
    step();
    chk("wr_end_busy", busy_a, 0);
    chk("wr_end_write", ia.write, 0);
    chk("wr_end_resp", ia.resp_valid, 0);
    chk("wr_end_accept", ia.req_accept, 0);

    // both channels continuously valid: alternation vs. starvation
    ia.req_valid = 2'b11; ia.req_write = 2'b11;
    ib.req_valid = 2'b11; ib.req_write = 2'b11;
    ib.req_address[0] = 32'h10; ib.req_address[1] = 32'h20;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("rr_accept", ia.req_accept, 32'(exp_rr[i]));
      chk("fp_accept", ib.req_accept, 32'(exp_fp[i]));
    end
    ia.req_valid = 2'b00;
    ib.req_valid = 2'b00;

    // watchdog abort on a read with waitrequest stuck high
    ia.req_valid = 2'b01; ia.req_write = 2'b00;
    ia.req_address[0] = 32'h0000_3000; ia.waitrequest = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      step();
      chk("wd_stall_read", ia.read, 1);
      chk("wd_stall_accept", ia.req_accept, 0);
      chk("wd_stall_err", err_a, 0);
    end
    step();
    chk("wd_abort_read", ia.read, 0);
    chk("wd_abort_write", ia.write, 0);
    chk("wd_abort_accept", ia.req_accept, 32'h1);
    chk("wd_abort_resp", ia.resp_valid, 32'h1);
    chk("wd_abort_rdata", ia.resp_readdata, 32'hDEAD_BEEF);
    chk("wd_abort_err", err_a, 1);
    ia.req_valid = 2'b00;
    step();
    chk("wd_idle_busy", busy_a, 0);
    chk("wd_idle_resp", ia.resp_valid, 0);
    repeat (3) step();
    chk("wd_sticky_err", err_a, 1);

    // reset in mid-BUS
    ia.req_valid = 2'b10; ia.req_write = 2'b00;
    ia.req_address[1] = 32'h0000_4000; ia.waitrequest = 1'b1;
    ia.readdata = 32'hA5A5_0001;
    step();
    chk("mr_read", ia.read, 1);
    chk("mr_addr", ia.address, 32'h0000_4000);
    #1 reset = 1'b0;
    #1;
    chk("mr_rst_read", ia.read, 0);
    chk("mr_rst_write", ia.write, 0);
    chk("mr_rst_busy", busy_a, 0);
    chk("mr_rst_err", err_a, 0);
    chk("mr_rst_accept", ia.req_accept, 0);
    ia.req_valid = 2'b11;
    ia.req_address[0] = 32'h0000_5000;
    ia.waitrequest = 1'b0;
    step();
    reset = 1'b1;
    #1;
    chk("mr_rel_accept", ia.req_accept, 0);
    chk("mr_rel_resp", ia.resp_valid, 0);
    step();
    chk("mr_first_accept", ia.req_accept, 32'h1);
    chk("mr_first_addr", ia.address, 32'h0000_5000);
    ia.req_valid = 2'b10;
    step();
    chk("mr_first_resp", ia.resp_valid, 32'h1);
    chk("mr_first_rdata", ia.resp_readdata, 32'hA5A5_0001);
    chk("mr_first_noacc", ia.req_accept, 0);
    step();
    chk("mr_idle_accept", ia.req_accept, 0);
    chk("mr_idle_resp", ia.resp_valid, 0);
    step();
    chk("mr_second_accept", ia.req_accept, 32'h2);
    chk("mr_second_addr", ia.address, 32'h0000_4000);
    ia.req_valid = 2'b00;
    step();
    chk("mr_second_resp", ia.resp_valid, 32'h2);
    step();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
